reg_update_sched: RTL and testbench

- Sequences all state updates into the architectural register file.
- Buffers ROB commit results in a small FIFO and drains them at one per cycle onto the register-file value-write port.
- Forwards decoder rename (dependency-set) requests onto the dep-write port.
- Owns the flush sequence: one-cycle dependency clear, then a recovery hold, with every input blocked while flushing.

---
 rtl/reg_update_sched.sv | 146 ++++++++++++++
 tb/tb_reg_update_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_update_sched.sv
// Register-file update scheduler: buffers ROB commits in a small FIFO that drains one entry
// per cycle, forwards rename dep-writes, and sequences the flush/clear/recover protocol.
module reg_update_sched #(
  parameter int ROB_W    = 5,
  parameter int DEPTH    = 4,
  parameter int HOLD_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             cm_valid,
  output logic             cm_ready,
  input  logic [4:0]       cm_rd,
  input  logic [31:0]      cm_val,
  input  logic [ROB_W-1:0] cm_rob,
  input  logic             rn_valid,
  output logic             rn_ready,
  input  logic [4:0]       rn_rd,
  input  logic [ROB_W-1:0] rn_rob,
  input  logic             flush_req,
  output logic             need_set_reg_value,
  output logic [4:0]       set_value_reg_id,
  output logic [31:0]      set_val,
  output logic [ROB_W-1:0] set_reg_rob_id,
  output logic             need_set_reg_dep,
  output logic [4:0]       set_dep_reg_id,
  output logic [ROB_W-1:0] set_dep_rob_id,
  output logic             clear,
  output logic             busy,
  output logic [31:0]      retired_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int HC_W  = $clog2(HOLD_CYC + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [HC_W-1:0]  HOLD_LD  = HC_W'(HOLD_CYC);
  localparam logic [HC_W-1:0]  HOLD_ONE = HC_W'(1);

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    RECOVER
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [HC_W-1:0]  hold_cnt;
  logic             dep_pend;

  logic [4:0]       fifo_rd  [DEPTH];
  logic [31:0]      fifo_val [DEPTH];
  logic [ROB_W-1:0] fifo_rob [DEPTH];

  logic run_ok;
  logic empty;
  logic push;
  logic pop;
  logic rn_acc;

  assign run_ok   = rdy && (state == RUN);
  assign empty    = (count == '0);
  assign cm_ready = run_ok && (count < FULL_CNT);
  assign rn_ready = run_ok;
  assign push     = cm_valid && cm_ready;
  assign pop      = run_ok && !empty;
  assign rn_acc   = rn_valid && rn_ready;

  assign set_value_reg_id   = fifo_rd[rd_ptr];
  assign set_val            = fifo_val[rd_ptr];
  assign set_reg_rob_id     = fifo_rob[rd_ptr];
  // rd==0 entries still pop and retire, they just never strobe the regfile
  assign need_set_reg_value = pop && (fifo_rd[rd_ptr] != '0);
  assign need_set_reg_dep   = rdy && dep_pend;
  assign clear              = rdy && (state == FLUSH);
  assign busy               = (state != RUN) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]  <= cm_rd;
      fifo_val[wr_ptr] <= cm_val;
      fifo_rob[wr_ptr] <= cm_rob;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      hold_cnt       <= '0;
      dep_pend       <= 1'b0;
      set_dep_reg_id <= '0;
      set_dep_rob_id <= '0;
      retired_cnt    <= '0;
    end else if (rdy) begin
      if (pop) begin
        retired_cnt <= retired_cnt + 32'd1;
      end
      dep_pend <= rn_acc && (rn_rd != '0);
      if (rn_acc && (rn_rd != '0)) begin
        set_dep_reg_id <= rn_rd;
        set_dep_rob_id <= rn_rob;
      end
      // A flush overrides everything accepted this cycle: FIFO and pending dep are dropped
      if (flush_req) begin
        state    <= FLUSH;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        dep_pend <= 1'b0;
      end else begin
        unique case (state)
          RUN: begin
            if (push) begin
              wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
              rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
              count <= count + 1'b1;
            end else if (pop && !push) begin
              count <= count - 1'b1;
            end
          end
          FLUSH: begin
            state    <= RECOVER;
            hold_cnt <= HOLD_LD;
          end
          RECOVER: begin
            if (hold_cnt == HOLD_ONE) begin
              state <= RUN;
            end
            hold_cnt <= hold_cnt - 1'b1;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reg_update_sched.sv
// Self-checking bench for reg_update_sched: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_reg_update_sched;

  localparam int ROB_W    = 5;
  localparam int DEPTH    = 4;
  localparam int HOLD_CYC = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rdy = 1'b1;
  logic             cm_valid = 1'b0;
  logic             cm_ready;
  logic [4:0]       cm_rd = '0;
  logic [31:0]      cm_val = '0;
  logic [ROB_W-1:0] cm_rob = '0;
  logic             rn_valid = 1'b0;
  logic             rn_ready;
  logic [4:0]       rn_rd = '0;
  logic [ROB_W-1:0] rn_rob = '0;
  logic             flush_req = 1'b0;
  logic             need_set_reg_value;
  logic [4:0]       set_value_reg_id;
  logic [31:0]      set_val;
  logic [ROB_W-1:0] set_reg_rob_id;
  logic             need_set_reg_dep;
  logic [4:0]       set_dep_reg_id;
  logic [ROB_W-1:0] set_dep_rob_id;
  logic             clear;
  logic             busy;
  logic [31:0]      retired_cnt;

  reg_update_sched #(
    .ROB_W(ROB_W),
    .DEPTH(DEPTH),
    .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .cm_valid(cm_valid),
    .cm_ready(cm_ready),
    .cm_rd(cm_rd),
    .cm_val(cm_val),
    .cm_rob(cm_rob),
    .rn_valid(rn_valid),
    .rn_ready(rn_ready),
    .rn_rd(rn_rd),
    .rn_rob(rn_rob),
    .flush_req(flush_req),
    .need_set_reg_value(need_set_reg_value),
    .set_value_reg_id(set_value_reg_id),
    .set_val(set_val),
    .set_reg_rob_id(set_reg_rob_id),
    .need_set_reg_dep(need_set_reg_dep),
    .set_dep_reg_id(set_dep_reg_id),
    .set_dep_rob_id(set_dep_rob_id),
    .clear(clear),
    .busy(busy),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit done   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [4:0]       rd;
    logic [31:0]      val;
    logic [ROB_W-1:0] rob;
  } ent_t;

  // Model: commit queue, blocked-cycle countdown (HOLD_CYC+1 means the clear cycle)
  ent_t             q[$];
  int               phase = 0;
  bit               m_dep = 1'b0;
  logic [4:0]       m_dep_rd = '0;
  logic [ROB_W-1:0] m_dep_rob = '0;
  logic [31:0]      m_ret = '0;

  always @(negedge clk) begin
    bit   run;
    bit   cmr;
    bit   vs;
    bit   rn_acc;
    ent_t e;
    if (!done) begin
      run = (phase == 0);
      cmr = rdy && run && (q.size() < DEPTH);
      vs  = rdy && run && (q.size() > 0) && (q[0].rd != 5'd0);
      chk("cm_ready", 32'(cm_ready), 32'(cmr));
      chk("rn_ready", 32'(rn_ready), 32'(rdy && run));
      chk("val_strobe", 32'(need_set_reg_value), 32'(vs));
      if (vs) begin
        chk("val_rd", 32'(set_value_reg_id), 32'(q[0].rd));
        chk("val_data", set_val, q[0].val);
        chk("val_rob", 32'(set_reg_rob_id), 32'(q[0].rob));
      end
      chk("dep_strobe", 32'(need_set_reg_dep), 32'(rdy && m_dep));
      if (rdy && m_dep) begin
        chk("dep_rd", 32'(set_dep_reg_id), 32'(m_dep_rd));
        chk("dep_rob", 32'(set_dep_rob_id), 32'(m_dep_rob));
      end
      chk("clear", 32'(clear), 32'(rdy && (phase == HOLD_CYC + 1)));
      chk("busy", 32'(busy), 32'(!run || (q.size() > 0)));
      chk("retired_cnt", retired_cnt, m_ret);

      if (rst) begin
        q.delete();
        phase = 0;
        m_dep = 1'b0;
        m_ret = '0;
      end else if (rdy) begin
        rn_acc = rn_valid && run;
        if (run && (q.size() > 0)) begin
          void'(q.pop_front());
          m_ret = m_ret + 32'd1;
        end
        if (cm_valid && cmr) begin
          e.rd  = cm_rd;
          e.val = cm_val;
          e.rob = cm_rob;
          q.push_back(e);
        end
        m_dep = rn_acc && (rn_rd != 5'd0);
        if (m_dep) begin
          m_dep_rd  = rn_rd;
          m_dep_rob = rn_rob;
        end
        if (flush_req) begin
          q.delete();
          m_dep = 1'b0;
          phase = HOLD_CYC + 1;
        end else if (phase > 0) begin
          phase--;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc();
    cyc();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_retired", retired_cnt, 32'd0);
    chk("rst_clear", 32'(clear), 32'd0);
    chk("rst_dep", 32'(need_set_reg_dep), 32'd0);
    rst = 1'b0;

    // Two consecutive commits drain in order
    cm_valid = 1'b1; cm_rd = 5'd5; cm_val = 32'h11; cm_rob = 5'd3;
    cyc();
    cm_rd = 5'd6; cm_val = 32'h22; cm_rob = 5'd4;
    #1;
    chk("a_strobe1", 32'(need_set_reg_value), 32'd1);
    chk("a_rd1", 32'(set_value_reg_id), 32'd5);
    chk("a_val1", set_val, 32'h11);
    chk("a_rob1", 32'(set_reg_rob_id), 32'd3);
    cyc();
    cm_valid = 1'b0;
    #1;
    chk("a_strobe2", 32'(need_set_reg_value), 32'd1);
    chk("a_rd2", 32'(set_value_reg_id), 32'd6);
    chk("a_val2", set_val, 32'h22);
    cyc();
    #1;
    chk("a_idle", 32'(need_set_reg_value), 32'd0);
    chk("a_retired", retired_cnt, 32'd2);

    // rd==0 commit retires silently
    cm_valid = 1'b1; cm_rd = 5'd0; cm_val = 32'hFFFF; cm_rob = 5'd1;
    cyc();
    cm_valid = 1'b0;
    #1;
    chk("z_strobe", 32'(need_set_reg_value), 32'd0);
    chk("z_busy", 32'(busy), 32'd1);
    cyc();
    #1;
    chk("z_retired", retired_cnt, 32'd3);
    chk("z_busy_after", 32'(busy), 32'd0);

    // Rename forwarding
    rn_valid = 1'b1; rn_rd = 5'd7; rn_rob = 5'd9;
    cyc();
    rn_valid = 1'b0;
    #1;
    chk("r_strobe", 32'(need_set_reg_dep), 32'd1);
    chk("r_rd", 32'(set_dep_reg_id), 32'd7);
    chk("r_rob", 32'(set_dep_rob_id), 32'd9);
    cyc();
    #1;
    chk("r_one_cycle", 32'(need_set_reg_dep), 32'd0);
    rn_valid = 1'b1; rn_rd = 5'd0;
    cyc();
    rn_valid = 1'b0;
    #1;
    chk("r_zero", 32'(need_set_reg_dep), 32'd0);

    // Dep strobe held across rdy=0 and re-presented
    rn_valid = 1'b1; rn_rd = 5'd12; rn_rob = 5'd20;
    cyc();
    rn_valid = 1'b0; rdy = 1'b0;
    #1;
    chk("f_dep_gated", 32'(need_set_reg_dep), 32'd0);
    chk("f_cm_ready", 32'(cm_ready), 32'd0);
    cyc();
    #1;
    chk("f_dep_held", 32'(need_set_reg_dep), 32'd0);
    rdy = 1'b1;
    #1;
    chk("f_dep_back", 32'(need_set_reg_dep), 32'd1);
    chk("f_dep_rd", 32'(set_dep_reg_id), 32'd12);
    cyc();
    #1;
    chk("f_dep_done", 32'(need_set_reg_dep), 32'd0);

    // Flush with a head entry popping and a same-cycle push that gets discarded
    cm_valid = 1'b1; cm_rd = 5'd9; cm_val = 32'h33; cm_rob = 5'd2;
    cyc();
    flush_req = 1'b1; cm_rd = 5'd10; cm_val = 32'h44;
    #1;
    chk("x_last_pop", 32'(need_set_reg_value), 32'd1);
    cyc();
    flush_req = 1'b0; cm_valid = 1'b0;
    #1;
    chk("x_clear", 32'(clear), 32'd1);
    chk("x_cm_ready", 32'(cm_ready), 32'd0);
    chk("x_rn_ready", 32'(rn_ready), 32'd0);
    chk("x_no_strobe", 32'(need_set_reg_value), 32'd0);
    for (int k = 0; k < HOLD_CYC; k++) begin
      cyc();
      #1;
      chk("x_rec_clear", 32'(clear), 32'd0);
      chk("x_rec_ready", 32'(cm_ready), 32'd0);
    end
    cyc();
    #1;
    chk("x_run_ready", 32'(cm_ready), 32'd1);
    chk("x_busy", 32'(busy), 32'd0);
    chk("x_retired", retired_cnt, 32'd4);

    // Second flush during RECOVER restarts the sequence
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    #1;
    chk("y_clear1", 32'(clear), 32'd1);
    cyc();
    flush_req = 1'b1;
    #1;
    chk("y_rec", 32'(clear), 32'd0);
    cyc();
    flush_req = 1'b0;
    #1;
    chk("y_clear2", 32'(clear), 32'd1);
    for (int k = 0; k < HOLD_CYC; k++) begin
      cyc();
      #1;
      chk("y_rec_ready", 32'(rn_ready), 32'd0);
    end
    cyc();
    #1;
    chk("y_run", 32'(rn_ready), 32'd1);

    // Reset mid-flush
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("q_busy", 32'(busy), 32'd0);
    chk("q_clear", 32'(clear), 32'd0);
    chk("q_retired", retired_cnt, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      rdy       = ($urandom_range(0, 9) != 0);
      cm_valid  = 1'($urandom_range(0, 1));
      cm_rd     = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      cm_val    = $urandom;
      cm_rob    = ROB_W'($urandom);
      rn_valid  = 1'($urandom_range(0, 1));
      rn_rd     = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      rn_rob    = ROB_W'($urandom);
      flush_req = ($urandom_range(0, 39) == 0);
      cyc();
    end

    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
